// File: rtl/addsub_seq_ctrl.sv
// Valid/ready sequencer around an external ripple-carry adder/subtractor:
// launches operands, waits a fixed settle time, captures S/V and counts overflows.
module addsub_seq_ctrl #(
  parameter int WIDTH         = 15,
  parameter int SETTLE_CYCLES = 2,
  parameter int OVF_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sub,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_c0,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_s,
  output logic                 out_v,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch registers stay put until the next accept so the adder output is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a  <= '0;
      add_b  <= '0;
      add_c0 <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      add_a  <= in_a;
      add_b  <= in_b;
      add_c0 <= in_sub;
      cnt    <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE && cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_s     <= '0;
      out_v     <= 1'b0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_s     <= add_s;
      out_v     <= add_v;
      out_valid <= 1'b1;
    end else if (done) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a simultaneous overflow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf_count <= '0;
    else if (ovf_clr)                            ovf_count <= '0;
    else if (capture && add_v && ovf_count != '1) ovf_count <= ovf_count + OVF_CNT_W'(1);
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl with a behavioural 15-bit adder/subtractor on the add_* ports.
module tb_addsub_seq_ctrl;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;

  logic         in_ready, add_c0, add_v, out_valid, out_v, busy;
  logic [W-1:0] add_a, add_b, add_s, out_s;
  logic [7:0]   ovf_count;

  logic         in_ready2, add_c02, add_v2, out_valid2, out_v2, busy2;
  logic [W-1:0] add_a2, add_b2, add_s2, out_s2;
  logic [1:0]   ovf_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0);
    logic [W-1:0] bb, s;
    bb = c0 ? ~b : b;
    s  = a + bb + {{(W-1){1'b0}}, c0};
    return {(a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]), s};
  endfunction

  assign {add_v, add_s}   = adder(add_a, add_b, add_c0);
  assign {add_v2, add_s2} = adder(add_a2, add_b2, add_c02);

  addsub_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2), .OVF_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s), .add_v(add_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_v(out_v),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count), .busy(busy)
  );

  addsub_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2), .OVF_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a2), .add_b(add_b2), .add_c0(add_c02), .add_s(add_s2), .add_v(add_v2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_s(out_s2), .out_v(out_v2),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready=1; optional ovf_clr on the capture edge.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] exp_s, input logic exp_v,
                       input logic clr);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    tick();
    check({tag, " busy"},      32'(busy), 1);
    check({tag, " in_ready0"}, 32'(in_ready), 0);
    check({tag, " add_a"},     32'(add_a), 32'(a));
    check({tag, " add_c0"},    32'(add_c0), 32'(sub));
    check({tag, " early_vld"}, 32'(out_valid), 0);
    in_valid = 1'b0;
    tick();
    check({tag, " lat_vld"},   32'(out_valid), 0);
    ovf_clr = clr;
    tick();
    ovf_clr = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 1);
    check({tag, " out_s"},     32'(out_s), 32'(exp_s));
    check({tag, " out_v"},     32'(out_v), 32'(exp_v));
    tick();
    check({tag, " vld_drop"},  32'(out_valid), 0);
    check({tag, " in_ready1"}, 32'(in_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst in_ready",  32'(in_ready), 1);
    check("rst busy",      32'(busy), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst add_a",     32'(add_a), 0);
    check("rst ovf_count", 32'(ovf_count), 0);
    rst_n = 1'b1;
    tick();

    do_op("add", 15'd100, 15'd23, 1'b0, 15'd123, 1'b0, 1'b0);
    do_op("sub", 15'd5, 15'd9, 1'b1, 15'h7FFC, 1'b0, 1'b0);
    check("sub ovf_count", 32'(ovf_count), 0);
    do_op("ovf_add", 15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b1, 1'b0);
    check("ovf_add count", 32'(ovf_count), 1);
    do_op("ovf_sub", 15'h4000, 15'h0001, 1'b1, 15'h3FFF, 1'b1, 1'b0);
    check("ovf_sub count", 32'(ovf_count), 2);
    check("ovf_sub count2", 32'(ovf_count2), 2);

    // Backpressure: result must hold while a new request waits.
    out_ready = 1'b0;
    in_a = 15'd1; in_b = 15'd2; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bp capture", 32'(out_s), 3);
    in_a = 15'd7; in_b = 15'd8; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid", 32'(out_valid), 1);
      check("bp out_s",     32'(out_s), 3);
      check("bp in_ready",  32'(in_ready), 0);
      check("bp add_a",     32'(add_a), 1);
      check("bp add_b",     32'(add_b), 2);
    end
    out_ready = 1'b1;
    tick();
    check("bp release vld", 32'(out_valid), 0);
    check("bp release rdy", 32'(in_ready), 1);
    tick();
    check("bp accept a", 32'(add_a), 7);
    check("bp accept b", 32'(add_b), 8);
    check("bp accept busy", 32'(busy), 1);
    in_valid = 1'b0;
    tick();
    tick();
    check("bp2 out_s", 32'(out_s), 15);
    tick();

    // Saturation on the 2-bit counter; the 8-bit one keeps counting.
    for (int i = 0; i < 4; i++)
      do_op("sat", 15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b1, 1'b0);
    check("sat count2", 32'(ovf_count2), 3);
    check("sat count8", 32'(ovf_count), 6);
    do_op("clr", 15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b1, 1'b1);
    check("clr count2", 32'(ovf_count2), 0);
    check("clr count8", 32'(ovf_count), 0);
    do_op("post_clr", 15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b1, 1'b0);
    check("post_clr count", 32'(ovf_count), 1);

    // Asynchronous reset in the middle of SETTLE.
    in_a = 15'd11; in_b = 15'd22; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst in_ready",  32'(in_ready), 1);
    check("arst busy",      32'(busy), 0);
    check("arst add_a",     32'(add_a), 0);
    check("arst out_s",     32'(out_s), 0);
    check("arst out_valid", 32'(out_valid), 0);
    check("arst ovf_count", 32'(ovf_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst no pulse", 32'(out_valid), 0);
    end
    do_op("after_rst", 15'd10, 15'd20, 1'b0, 15'd30, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
